// File: rtl/mm_pkg.sv
// Shared types and sizing helpers for the streaming matrix multiplier.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    OUT,
    DONE
  } state_t;

  // Largest supported operand dimension; index/dimension counters are sized
  // for it so they can also hold MAXDIM+1 (an oversize row/column count).
  localparam int MAXDIM_CAP = 8;
  localparam int IW         = $clog2(MAXDIM_CAP + 1);

  // Smallest result width that can hold a full dot product without overflow.
  function automatic int mm_ow_min(input int dw, input int maxdim);
    return 2 * dw + $clog2(maxdim);
  endfunction

endpackage

// File: rtl/mm_mac.sv
// Multiply-accumulate unit: DW x DW product, sign/zero extended to OW,
// accumulated modulo 2^OW. clr together with en starts a new sum with the
// current product; clr alone zeroes the accumulator.
module mm_mac #(
  parameter int DW = 8,
  parameter int OW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          signed_mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [OW-1:0] acc
);

  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] b_ext;
  logic [2*DW-1:0] prod;
  logic [OW-1:0]   prod_ext;

  // Extend operands to 2*DW so a plain modular multiply gives the right
  // product for both signed and unsigned operands, then extend to OW.
  always_comb begin
    a_ext    = signed_mode ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    b_ext    = signed_mode ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    prod     = a_ext * b_ext;
    prod_ext = signed_mode ? {{(OW-2*DW){prod[2*DW-1]}}, prod}
                           : {{(OW-2*DW){1'b0}}, prod};
  end

  // Accumulator register.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? prod_ext : acc + prod_ext;
    end else if (clr) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/mm_param.sv
// Streaming matrix multiplier C = A x B. Loads A then B row-major from one
// framed input stream, computes C with one MAC per cycle, then streams C out
// row-major. Shape mismatches and oversize operands yield one illegal beat.
module mm_param
  import mm_pkg::*;
#(
  parameter int DW     = 8,
  parameter int MAXDIM = 4,
  parameter int OW     = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          col_end,
  input  logic          row_end,
  input  logic          signed_mode,
  output logic          busy,
  output logic          valid,
  output logic [OW-1:0] out_data,
  output logic          is_legal,
  output logic          change_row
);

  if (OW < mm_ow_min(DW, MAXDIM)) begin : g_bad_ow
    $error("mm_param: OW must be at least 2*DW+clog2(MAXDIM)");
  end
  if (MAXDIM < 2 || MAXDIM > MAXDIM_CAP) begin : g_bad_dim
    $error("mm_param: MAXDIM must be in 2..8");
  end

  localparam int AW = $clog2(MAXDIM);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t MAX_I = idx_t'(MAXDIM);
  localparam idx_t ONE_I = idx_t'(1);

  state_t state, state_nxt;

  logic [DW-1:0] a_mem [MAXDIM][MAXDIM];
  logic [DW-1:0] b_mem [MAXDIM][MAXDIM];
  logic [OW-1:0] c_mem [MAXDIM][MAXDIM];

  idx_t lr, lc;                              // load row/col
  idx_t rows_a, cols_a, rows_b, cols_b;
  logic ovf, mode;
  idx_t ci, cj, ck;                          // compute indices
  logic wb_phase, wr_pend;
  idx_t wr_i, wr_j;
  idx_t oi, oj;                              // index of the beat on the outputs
  idx_t rd_i, rd_j;                          // index of the next beat
  logic [OW-1:0] acc, rd_val;

  logic accept, to_b, in_range, legal;
  logic mac_en, mac_clr, k_last, j_last, i_last, out_last;
  logic busy_nxt, valid_nxt, legal_nxt, cr_nxt;
  logic [OW-1:0] data_nxt;

  assign accept   = in_valid && (state inside {IDLE, LOAD_A, LOAD_B});
  assign to_b     = (state == LOAD_B);
  assign in_range = (lr < MAX_I) && (lc < MAX_I);
  assign legal    = !ovf && (cols_a == rows_b);
  assign mac_en   = (state == CALC) && legal && !wb_phase;
  assign mac_clr  = mac_en && (ck == '0);
  assign k_last   = (ck == cols_a - ONE_I);
  assign j_last   = (cj == cols_b - ONE_I);
  assign i_last   = (ci == rows_a - ONE_I);
  assign out_last = (oi == rows_a - ONE_I) && (oj == cols_b - ONE_I);

  mm_mac #(.DW(DW), .OW(OW)) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr        (mac_clr),
    .en         (mac_en),
    .signed_mode(mode),
    .a          (a_mem[ci[AW-1:0]][ck[AW-1:0]]),
    .b          (b_mem[ck[AW-1:0]][cj[AW-1:0]]),
    .acc        (acc)
  );

  // Next output index and its value; the final C element may still be in
  // the accumulator waiting to be written, so it is bypassed.
  always_comb begin
    rd_i = oi;
    rd_j = oj + ONE_I;
    if (state == CALC) begin
      rd_i = '0;
      rd_j = '0;
    end else if (oj == cols_b - ONE_I) begin
      rd_i = oi + ONE_I;
      rd_j = '0;
    end
    rd_val = (wr_pend && wr_i == rd_i && wr_j == rd_j)
             ? acc : c_mem[rd_i[AW-1:0]][rd_j[AW-1:0]];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-output decode.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    legal_nxt = 1'b0;
    cr_nxt    = 1'b0;
    data_nxt  = '0;
    case (state)
      IDLE:    if (in_valid) state_nxt = row_end ? LOAD_B : LOAD_A;
      LOAD_A:  if (in_valid && row_end) state_nxt = LOAD_B;
      LOAD_B:  if (in_valid && row_end) state_nxt = CALC;
      CALC:    if (!legal || wb_phase) state_nxt = OUT;
      OUT:     if (!legal || out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = state_nxt inside {CALC, OUT, DONE};
    if (state_nxt == OUT) begin
      valid_nxt = 1'b1;
      legal_nxt = legal;
      data_nxt  = legal ? rd_val : '0;
      cr_nxt    = !legal || (rd_j == cols_b - ONE_I);
    end
  end

  // Operand loading: store in-range elements, track indices, latch shapes.
  // NOTE: the operand and result arrays are cleared on reset and again in
  // DONE, so ragged rows read back as zeros instead of stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || state == DONE) begin
      for (int r = 0; r < MAXDIM; r++)
        for (int c = 0; c < MAXDIM; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      lr <= '0;  lc <= '0;
      rows_a <= '0;  cols_a <= '0;
      rows_b <= '0;  cols_b <= '0;
      ovf <= 1'b0;
      mode <= 1'b0;
    end else if (accept) begin
      if (!in_range)  ovf <= 1'b1;
      else if (to_b)  b_mem[lr[AW-1:0]][lc[AW-1:0]] <= in_data;
      else            a_mem[lr[AW-1:0]][lc[AW-1:0]] <= in_data;
      if (state == IDLE) mode <= signed_mode;
      if (row_end) begin
        lr <= '0;
        lc <= '0;
        if (to_b) begin
          rows_b <= lr + ONE_I;
          cols_b <= lc + ONE_I;
        end else begin
          rows_a <= lr + ONE_I;
          cols_a <= lc + ONE_I;
        end
      end else if (col_end) begin
        lc <= '0;
        if (lr != MAX_I) lr <= lr + ONE_I;
      end else if (lc != MAX_I) begin
        lc <= lc + ONE_I;
      end
    end
  end

  // Compute sequencing: walk k, then j, then i; each finished sum is written
  // to C the cycle after its last MAC, hence one write-back cycle at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || state == DONE) begin
      for (int r = 0; r < MAXDIM; r++)
        for (int c = 0; c < MAXDIM; c++)
          c_mem[r][c] <= '0;
      ci <= '0;  cj <= '0;  ck <= '0;
      wb_phase <= 1'b0;
      wr_pend  <= 1'b0;
      wr_i <= '0;  wr_j <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (wr_pend) c_mem[wr_i[AW-1:0]][wr_j[AW-1:0]] <= acc;
      if (mac_en) begin
        if (k_last) begin
          ck      <= '0;
          wr_pend <= 1'b1;
          wr_i    <= ci;
          wr_j    <= cj;
          if (j_last) begin
            cj <= '0;
            if (i_last) wb_phase <= 1'b1;
            else        ci <= ci + ONE_I;
          end else begin
            cj <= cj + ONE_I;
          end
        end else begin
          ck <= ck + ONE_I;
        end
      end
    end
  end

  // Output register and the index of the beat it currently shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      valid      <= 1'b0;
      out_data   <= '0;
      is_legal   <= 1'b0;
      change_row <= 1'b0;
      oi <= '0;
      oj <= '0;
    end else begin
      busy       <= busy_nxt;
      valid      <= valid_nxt;
      out_data   <= data_nxt;
      is_legal   <= legal_nxt;
      change_row <= cr_nxt;
      if (state_nxt == OUT) begin
        oi <= rd_i;
        oj <= rd_j;
      end else begin
        oi <= '0;
        oj <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mm_param.sv
// Self-checking bench for mm_param: directed frames plus random shapes,
// checked against a plain-arithmetic matrix product model.
module tb_mm_param;

  localparam int DW     = 8;
  localparam int MAXDIM = 4;
  localparam int OW     = 20;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          col_end;
  logic          row_end;
  logic          signed_mode;
  logic          busy;
  logic          valid;
  logic [OW-1:0] out_data;
  logic          is_legal;
  logic          change_row;

  mm_param #(.DW(DW), .MAXDIM(MAXDIM), .OW(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .col_end    (col_end),
    .row_end    (row_end),
    .signed_mode(signed_mode),
    .busy       (busy),
    .valid      (valid),
    .out_data   (out_data),
    .is_legal   (is_legal),
    .change_row (change_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    bit     legal;
    bit     cr;
  } beat_t;

  int    a_el[$], a_rl[$], b_el[$], b_rl[$];
  beat_t exp_q[$];
  int    exp_lat;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic longint as_val(input int e, input bit sm);
    logic [DW-1:0] v;
    v = e[DW-1:0];
    if (sm) return longint'($signed(v));
    return longint'(v);
  endfunction

  // Reference: rebuild both operands from the element stream, then C = A x B.
  task automatic build_expected(input bit sm);
    longint m[2][MAXDIM][MAXDIM];
    int     rows[2];
    int     cols[2];
    bit     ovf;
    bit     legal;
    longint mask;
    ovf  = 0;
    mask = (longint'(1) << OW) - 1;
    for (int w = 0; w < 2; w++)
      for (int r = 0; r < MAXDIM; r++)
        for (int c = 0; c < MAXDIM; c++) m[w][r][c] = 0;
    for (int w = 0; w < 2; w++) begin
      int idx;
      int nr;
      idx = 0;
      nr  = (w == 0) ? a_rl.size() : b_rl.size();
      rows[w] = nr;
      cols[w] = 0;
      for (int r = 0; r < nr; r++) begin
        int len;
        len = (w == 0) ? a_rl[r] : b_rl[r];
        cols[w] = len;
        for (int c = 0; c < len; c++) begin
          int e;
          e = (w == 0) ? a_el[idx] : b_el[idx];
          idx++;
          if (r < MAXDIM && c < MAXDIM) m[w][r][c] = as_val(e, sm);
          else                          ovf = 1;
        end
      end
    end
    legal = !ovf && (cols[0] == rows[1]);
    exp_q.delete();
    if (!legal) begin
      exp_q.push_back('{data: 0, legal: 0, cr: 1});
      exp_lat = 1;
    end else begin
      for (int i = 0; i < rows[0]; i++)
        for (int j = 0; j < cols[1]; j++) begin
          longint s;
          s = 0;
          for (int k = 0; k < cols[0]; k++) s += m[0][i][k] * m[1][k][j];
          exp_q.push_back('{data: s & mask, legal: 1, cr: (j == cols[1] - 1)});
        end
      exp_lat = 1 + rows[0] * cols[1] * cols[0];
    end
  endtask

  task automatic send(input bit which, input bit sm, input int stall_at);
    int idx;
    int nr;
    idx = 0;
    nr  = which ? b_rl.size() : a_rl.size();
    for (int r = 0; r < nr; r++) begin
      int len;
      len = which ? b_rl[r] : a_rl[r];
      for (int c = 0; c < len; c++) begin
        if (idx == stall_at) repeat (3) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = DW'(which ? b_el[idx] : a_el[idx]);
        col_end     = (c == len - 1);
        row_end     = (c == len - 1) && (r == nr - 1);
        signed_mode = sm;
        idx++;
      end
    end
  endtask

  // Counts cycles from B's row_end edge to the first valid beat.
  task automatic wait_first(input string name, input bit junk, output bit ok);
    int n;
    n  = 0;
    ok = 0;
    while (n < BUDGET) begin
      @(negedge clk);
      if (junk) begin
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        col_end  = 1'($urandom);
        row_end  = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (n == 0) check({name, ":busy_rise"}, 64'(busy), 64'(1));
      if (valid) begin
        ok = 1;
        break;
      end
      n++;
    end
    check({name, ":latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic check_beat(input string name, input int b);
    check($sformatf("%s:valid%0d", name, b), 64'(valid), 64'(1));
    check($sformatf("%s:data%0d", name, b), 64'(out_data), 64'(exp_q[b].data));
    check($sformatf("%s:legal%0d", name, b), 64'(is_legal), 64'(exp_q[b].legal));
    check($sformatf("%s:cr%0d", name, b), 64'(change_row), 64'(exp_q[b].cr));
  endtask

  task automatic run_case(input string name, input bit sm, input int stall_at, input bit junk);
    bit ok;
    build_expected(sm);
    send(0, sm, -1);
    send(1, sm, stall_at);
    wait_first(name, junk, ok);
    if (!ok) return;
    for (int b = 0; b < exp_q.size(); b++) begin
      if (b > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      check_beat(name, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({name, ":done_valid"}, 64'(valid), 64'(0));
    check({name, ":done_busy"}, 64'(busy), 64'(1));
    @(negedge clk);
    check({name, ":busy_fall"}, 64'(busy), 64'(0));
  endtask

  task automatic set_case1();
    a_el = '{1, 2, 3, 4, 5, 6};     a_rl = '{3, 3};
    b_el = '{7, 8, 9, 10, 11, 12};  b_rl = '{2, 2, 2};
  endtask

  initial begin
    bit ok;
    int ra, ca, rb, cb;
    bit sm;
    rst = 1'b0;  in_valid = 1'b0;  in_data = '0;
    col_end = 1'b0;  row_end = 1'b0;  signed_mode = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst:busy", 64'(busy), 64'(0));
    check("rst:valid", 64'(valid), 64'(0));
    check("rst:data", 64'(out_data), 64'(0));
    check("rst:legal", 64'(is_legal), 64'(0));
    check("rst:cr", 64'(change_row), 64'(0));
    rst = 1'b0;

    set_case1();
    run_case("c1", 0, -1, 0);

    a_el = '{1, 2, 3, 4};           a_rl = '{2, 2};
    b_el = '{1, 2, 3, 4, 5, 6};     b_rl = '{2, 2, 2};
    run_case("c2", 0, -1, 0);

    a_el.delete();  a_rl = '{4, 4, 4, 4};
    b_el.delete();  b_rl = '{4, 4, 4, 4};
    for (int i = 0; i < 16; i++) begin
      a_el.push_back(-128);
      b_el.push_back(-128);
    end
    run_case("c3", 1, -1, 0);

    a_el = '{1, 2, 3, 4, 5};        a_rl = '{5};
    b_el = '{1, 2, 3, 4};           b_rl = '{2, 2};
    run_case("c4a", 0, -1, 0);
    a_el = '{3};   a_rl = '{1};
    b_el = '{-2};  b_rl = '{1};
    run_case("c4b", 1, -1, 0);

    set_case1();
    run_case("c5", 0, 3, 1);

    set_case1();
    build_expected(0);
    send(0, 0, -1);
    send(1, 0, -1);
    wait_first("c6", 0, ok);
    if (ok) begin
      check_beat("c6", 0);
      @(negedge clk);
      check_beat("c6", 1);
      #2 rst = 1'b1;
      #1;
      check("c6:rst_valid", 64'(valid), 64'(0));
      check("c6:rst_data", 64'(out_data), 64'(0));
      check("c6:rst_busy", 64'(busy), 64'(0));
      check("c6:rst_cr", 64'(change_row), 64'(0));
      @(negedge clk);
      rst = 1'b0;
    end
    set_case1();
    run_case("c6b", 0, -1, 0);

    for (int t = 0; t < 8; t++) begin
      ra = $urandom_range(1, MAXDIM);
      ca = $urandom_range(1, MAXDIM);
      cb = $urandom_range(1, MAXDIM);
      rb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MAXDIM) : ca;
      sm = 1'($urandom);
      a_el.delete();  a_rl.delete();  b_el.delete();  b_rl.delete();
      for (int r = 0; r < ra; r++) a_rl.push_back(ca);
      for (int r = 0; r < rb; r++) b_rl.push_back(cb);
      for (int i = 0; i < ra * ca; i++) a_el.push_back(int'($urandom_range(0, 255)));
      for (int i = 0; i < rb * cb; i++) b_el.push_back(int'($urandom_range(0, 255)));
      run_case($sformatf("rnd%0d", t), sm, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
